// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command queue.
// Holds the operand mode width, default data width and command record.
package alu_pkg;

    localparam int MODE_W     = 4;
    localparam int DEF_DATA_W = 8;

    // Field order {a, b, mode, cin} is also the flat storage layout.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
        logic [MODE_W-1:0]     mode;
        logic                  cin;
    } alu_cmd_t;

    function automatic int cmd_w(input int dw);
        return 2 * dw + MODE_W + 1;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo_mem.sv
// Command storage: DEPTH x W array, one write port, one read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read, raddr registered upstream).
module alu_cmd_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 21
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_cmd_queue.sv
// Command queue feeding an ALU: buffers {a,b,mode,cin}, issues in order.
// Ports: CLK_IN/RST, CMD_* push side, ISSUE_EN/FLUSH, OPERA_*/MODE/CIN/OP_VALID
// issue side, LEVEL/EMPTY/FULL status; ISSUE_CNT when ALU_CMD_QUEUE_STATS_EN.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       CLK_IN,
    input  logic                       RST,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [DATA_W-1:0]          CMD_A,
    input  logic [DATA_W-1:0]          CMD_B,
    input  logic [MODE_W-1:0]          CMD_MODE,
    input  logic                       CMD_CIN,
    input  logic                       ISSUE_EN,
    input  logic                       FLUSH,
    output logic [DATA_W-1:0]          OPERA_A,
    output logic [DATA_W-1:0]          OPERA_B,
    output logic [MODE_W-1:0]          MODE,
    output logic                       CIN,
    output logic                       OP_VALID,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL,
    output logic                       EMPTY,
    output logic                       FULL
`ifdef ALU_CMD_QUEUE_STATS_EN
    ,
    output logic [15:0]                ISSUE_CNT
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CMD_W = cmd_w(DATA_W);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_FLUSHING = 2'd2;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       state_q, state_d;
    logic [CMD_W-1:0] out_q, out_d;
    logic             op_valid_q, op_valid_d;
    logic [CMD_W-1:0] wr_cmd, rd_cmd;
    logic             full, empty, push, pop;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign CMD_READY = !full && !FLUSH;
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = ISSUE_EN && !empty && !FLUSH;
    assign wr_cmd    = {CMD_A, CMD_B, CMD_MODE, CMD_CIN};

    alu_cmd_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_mem (
        .clk   (CLK_IN),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_cmd),
        .raddr (rd_ptr_q),
        .rdata (rd_cmd)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_d      = out_q;
        op_valid_d = 1'b0;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                out_d      = rd_cmd;
                op_valid_d = 1'b1;
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // A push on the edge FLUSH drops goes straight to ACTIVE so the
    // state never disagrees with a non-empty queue.
    always_comb begin
        state_d = state_q;
        if (FLUSH) begin
            state_d = ST_FLUSHING;
        end else begin
            case (state_q)
                ST_IDLE:     if (push) state_d = ST_ACTIVE;
                ST_ACTIVE:   if (level_d == '0) state_d = ST_IDLE;
                ST_FLUSHING: state_d = push ? ST_ACTIVE : ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= ST_IDLE;
            out_q      <= '0;
            op_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            out_q      <= out_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign {OPERA_A, OPERA_B, MODE, CIN} = out_q;
    assign OP_VALID = op_valid_q;
    assign LEVEL    = level_q;
    assign EMPTY    = empty;
    assign FULL     = full;

`ifdef ALU_CMD_QUEUE_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (pop && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            issue_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign ISSUE_CNT = issue_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue (DEPTH=8, DATA_W=8).
// Directed vectors plus a randomized stream; monitor checks issued ops.
module tb_alu_cmd_queue;
    import alu_pkg::*;

    logic       CLK_IN = 1'b0;
    logic       RST, CMD_VALID, CMD_READY, CMD_CIN, ISSUE_EN, FLUSH;
    logic [7:0] CMD_A, CMD_B, OPERA_A, OPERA_B;
    logic [3:0] CMD_MODE, MODE, LEVEL;
    logic       CIN, OP_VALID, EMPTY, FULL;
`ifdef ALU_CMD_QUEUE_STATS_EN
    logic [15:0] ISSUE_CNT;
`endif

    alu_cmd_t exp_q[$];
    int errors  = 0;
    int checks  = 0;
    int n_issue = 0;

    alu_cmd_queue #(.DEPTH(8), .DATA_W(8)) dut (
        .CLK_IN    (CLK_IN),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_A     (CMD_A),
        .CMD_B     (CMD_B),
        .CMD_MODE  (CMD_MODE),
        .CMD_CIN   (CMD_CIN),
        .ISSUE_EN  (ISSUE_EN),
        .FLUSH     (FLUSH),
        .OPERA_A   (OPERA_A),
        .OPERA_B   (OPERA_B),
        .MODE      (MODE),
        .CIN       (CIN),
        .OP_VALID  (OP_VALID),
        .LEVEL     (LEVEL),
        .EMPTY     (EMPTY),
        .FULL      (FULL)
`ifdef ALU_CMD_QUEUE_STATS_EN
        ,
        .ISSUE_CNT (ISSUE_CNT)
`endif
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // One clock: record the push/flush/reset the DUT sees at this edge.
    task automatic step(output bit acc);
        bit a, f, r;
        alu_cmd_t c;
        #1;
        a = CMD_VALID && CMD_READY && !RST;
        f = FLUSH;
        r = RST;
        c = {CMD_A, CMD_B, CMD_MODE, CMD_CIN};
        @(posedge CLK_IN);
        if (f || r) exp_q.delete();
        if (r) n_issue = 0;
        if (a) exp_q.push_back(c);
        acc = a;
        #1;
    endtask

    task automatic tick();
        bit x;
        step(x);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] m, input logic c);
        CMD_VALID = 1'b1;
        CMD_A = a;
        CMD_B = b;
        CMD_MODE = m;
        CMD_CIN = c;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
        tick();
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: every issued op must be the oldest outstanding push.
    initial begin
        alu_cmd_t got, e;
        forever begin
            @(negedge CLK_IN);
            if (OP_VALID === 1'b1) begin
                got = {OPERA_A, OPERA_B, MODE, CIN};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL op_unexpected got=%h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL op_order got=%h required=%h", got, e);
                    end
                end
                n_issue++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run, bad;
        bit acc;
        RST = 1'b1;
        CMD_VALID = 1'b0;
        CMD_A = '0;
        CMD_B = '0;
        CMD_MODE = '0;
        CMD_CIN = 1'b0;
        ISSUE_EN = 1'b0;
        FLUSH = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_level", LEVEL, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_opvalid", OP_VALID, 0);
        chk("rst_outs", {OPERA_A, OPERA_B, MODE, CIN}, 0);
        chk("rst_ready", CMD_READY, 1);

        // Latency: push at edge k, visible after edge k+1.
        ISSUE_EN = 1'b1;
        push(8'h12, 8'h34, 4'h3, 1'b1);
        chk("lat_k_opvalid", OP_VALID, 0);
        chk("lat_k_level", LEVEL, 1);
        tick();
        chk("lat_k1_opvalid", OP_VALID, 1);
        chk("lat_k1_outs", {OPERA_A, OPERA_B, MODE, CIN},
            {8'h12, 8'h34, 4'h3, 1'b1});
        tick();
        chk("lat_pulse_end", OP_VALID, 0);
        chk("lat_hold", {OPERA_A, OPERA_B, MODE, CIN},
            {8'h12, 8'h34, 4'h3, 1'b1});

        // Fill to full, reject the 9th, then burst out.
        ISSUE_EN = 1'b0;
        for (int i = 0; i < 8; i++)
            push(8'h10 + 8'(i), 8'h80 + 8'(i), 4'(i), i[0]);
        chk("full_flag", FULL, 1);
        chk("full_ready", CMD_READY, 0);
        chk("full_level", LEVEL, 8);
        push(8'hAA, 8'hBB, 4'hF, 1'b1);
        chk("full_reject", LEVEL, 8);
        ISSUE_EN = 1'b1;
        run = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (OP_VALID === 1'b1) run++;
        end
        chk("burst_consec", run, 8);
        tick();
        chk("burst_done", {OP_VALID, EMPTY}, 2'b01);

        // Level 4, push and pop together for 10 cycles.
        ISSUE_EN = 1'b0;
        for (int i = 0; i < 4; i++)
            push(8'h20 + 8'(i), 8'h90 + 8'(i), 4'(i + 4), i[1]);
        chk("stream_start", LEVEL, 4);
        ISSUE_EN = 1'b1;
        CMD_VALID = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            CMD_A = 8'h40 + 8'(i);
            CMD_B = 8'h50 + 8'(i);
            CMD_MODE = 4'(i);
            CMD_CIN = i[0];
            tick();
            if (LEVEL !== 4'd4) bad++;
        end
        CMD_VALID = 1'b0;
        chk("stream_level", bad, 0);
        drain("stream_drain");

        // Flush at level 5 with a concurrent push.
        ISSUE_EN = 1'b0;
        for (int i = 0; i < 5; i++)
            push(8'h30 + 8'(i), 8'hA0 + 8'(i), 4'(i), 1'b0);
        chk("flush_pre", LEVEL, 5);
        FLUSH = 1'b1;
        CMD_VALID = 1'b1;
        CMD_A = 8'hEE;
        tick();
        FLUSH = 1'b0;
        CMD_VALID = 1'b0;
        chk("flush_level", LEVEL, 0);
        chk("flush_flags", {OP_VALID, EMPTY}, 2'b01);
        chk("flush_hold", {OPERA_A, OPERA_B, MODE, CIN},
            {8'h49, 8'h59, 4'h9, 1'b1});
        ISSUE_EN = 1'b1;
        run = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (OP_VALID === 1'b1) run++;
        end
        chk("flush_lost", run, 0);

        // Reset mid-stream with LEVEL=3 and an op in flight.
        ISSUE_EN = 1'b0;
        for (int i = 0; i < 4; i++)
            push(8'h60 + 8'(i), 8'hC0 + 8'(i), 4'(i + 8), 1'b1);
        ISSUE_EN = 1'b1;
        tick();
        chk("mid_level", LEVEL, 3);
        chk("mid_op", {OP_VALID, OPERA_A}, {1'b1, 8'h60});
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mrst_outs", {OP_VALID, OPERA_A, OPERA_B, MODE, CIN}, 0);
        chk("mrst_status", {LEVEL, EMPTY, FULL}, 6'b000010);
`ifdef ALU_CMD_QUEUE_STATS_EN
        chk("mrst_cnt", ISSUE_CNT, 0);
`endif
        tick();
        tick();
        chk("mrst_idle", OP_VALID, 0);

        // 30 random commands with random ISSUE_EN.
        for (int i = 0; i < 30; i++) begin
            CMD_VALID = 1'b1;
            CMD_A = 8'($urandom_range(0, 255));
            CMD_B = 8'($urandom_range(0, 255));
            CMD_MODE = 4'($urandom_range(0, 15));
            CMD_CIN = 1'($urandom_range(0, 1));
            acc = 1'b0;
            for (int n = 0; n < 50 && !acc; n++) begin
                ISSUE_EN = 1'($urandom_range(0, 1));
                step(acc);
            end
            if (!acc) chk("rand_accept", 0, 1);
        end
        CMD_VALID = 1'b0;
        ISSUE_EN = 1'b1;
        drain("rand_drain");
        chk("rand_count", n_issue, 30);
`ifdef ALU_CMD_QUEUE_STATS_EN
        chk("rand_cnt", ISSUE_CNT, 30);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of buffered commands (power of two, 2..64).
REQ-002 Parameter DATA_W, default 8, operand width matching the ALU operand ports.
REQ-003 CLK_IN  in  1  sole clock, all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 CMD_VALID  in  1  producer presents a command.
REQ-006 CMD_READY  out  1  queue accepts a command this cycle.
REQ-007 CMD_A, CMD_B  in  DATA_W each  command operands.
REQ-008 CMD_MODE  in  4  command ALU mode, all 16 codes legal.
REQ-009 CMD_CIN  in  1  command carry-in.
REQ-010 ISSUE_EN  in  1  downstream ALU may take a new operation.
REQ-011 FLUSH  in  1  discard all queued commands.
REQ-012 OPERA_A, OPERA_B  out  DATA_W each  issued operands to ALU.
REQ-013 MODE  out  4, CIN  out  1  issued mode and carry-in to ALU.
REQ-014 OP_VALID  out  1  one-cycle pulse per issued operation.
REQ-015 LEVEL  out  $clog2(DEPTH+1)  queued entry count; EMPTY, FULL  out  1  status flags.

Function
REQ-016 Push occurs on an edge where CMD_VALID && CMD_READY; CMD_READY SHALL equal !FULL && !FLUSH (combinational from registered state).
REQ-017 Pop occurs on an edge where ISSUE_EN && !EMPTY && !FLUSH; popped entry SHALL load OPERA_A/OPERA_B/MODE/CIN registers and set OP_VALID for exactly the following cycle.
REQ-018 Latency: command pushed at edge k into an empty queue with ISSUE_EN high SHALL appear on outputs with OP_VALID=1 after edge k+1; no same-cycle bypass.
REQ-019 When no pop occurs, OP_VALID SHALL be 0 and OPERA_A/OPERA_B/MODE/CIN SHALL hold last issued values.
REQ-020 Commands SHALL issue in strict push order; no reordering, no drops except via FLUSH or RST.
REQ-021 Simultaneous push and pop with 0<LEVEL<DEPTH SHALL leave LEVEL unchanged; push into empty with pop requested SHALL push only.
REQ-022 When FULL, push SHALL NOT occur even if a pop occurs on the same edge.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; FULL = (LEVEL==DEPTH), EMPTY = (LEVEL==0).
REQ-024 FLUSH high at edge SHALL set LEVEL=0, OP_VALID=0, discard any same-edge push and pop, and leave operand outputs holding.
REQ-025 Controller states: IDLE (EMPTY), ACTIVE (!EMPTY), FLUSHING (FLUSH high); IDLE->ACTIVE on push, ACTIVE->IDLE on pop of last entry, any->FLUSHING on FLUSH, FLUSHING->IDLE when FLUSH low.

Reset
REQ-026 RST high at edge SHALL set LEVEL=0, EMPTY=1, FULL=0, OP_VALID=0, OPERA_A=OPERA_B=0, MODE=0, CIN=0, pointers=0, state IDLE; RST dominates FLUSH, push and pop.
REQ-027 RST asserted mid-operation SHALL discard all queued and in-flight commands; storage contents need not be cleared.

Configuration
REQ-028 Macro ALU_CMD_QUEUE_STATS_EN, when defined, SHALL add output ISSUE_CNT [15:0] counting pops, saturating at 16'hFFFF, cleared by RST only (not FLUSH).
REQ-029 Without ALU_CMD_QUEUE_STATS_EN the ISSUE_CNT port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package alu_pkg SHALL hold MODE_W=4, default DATA_W=8, and the command record typedef {a, b, mode, cin}.
REQ-031 Storage SHALL be sub-module alu_cmd_fifo_mem (DEPTH x command record, one write port, one registered-address read port); control and output registers in alu_cmd_queue.

Verification
REQ-032 RST, then push A=8'h12,B=8'h34,MODE=4'h3,CIN=1 with ISSUE_EN=1 -> OP_VALID=1 two edges after push with those exact values.
REQ-033 ISSUE_EN=0, push 8 commands -> FULL=1, CMD_READY=0, LEVEL=8; 9th CMD_VALID not accepted; ISSUE_EN=1 -> 8 ops issue in push order on consecutive cycles.
REQ-034 LEVEL=4, simultaneous push and pop for 10 cycles -> LEVEL stays 4, pointers wrap, order preserved.
REQ-035 LEVEL=5, FLUSH one cycle with CMD_VALID=1 -> LEVEL=0, OP_VALID=0, pushed command lost, outputs hold.
REQ-036 RST mid-stream with LEVEL=3 and OP_VALID=1 -> next cycle all outputs zero, EMPTY=1; with ALU_CMD_QUEUE_STATS_EN, ISSUE_CNT=0.
REQ-037 30 random commands (operands in -128..127, MODE 0..15) with random ISSUE_EN -> issued stream equals pushed stream exactly.
